// File: rtl/msi_snoop_responder.sv
// Snoop-side MSI responder: resolves bus commands against the local tag/state
// arrays, downgrades or invalidates the line, and flushes Modified data word by word.
module msi_snoop_responder #(
    parameter int TAG_WIDTH      = 20,
    parameter int INDEX_WIDTH    = 6,
    parameter int WORDS_PER_LINE = 4,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              snoop_valid,
    output logic                              snoop_ready,
    input  logic [1:0]                        snoop_command,
    input  logic [TAG_WIDTH-1:0]              snoop_tag,
    input  logic [INDEX_WIDTH-1:0]            snoop_index,
    output logic [INDEX_WIDTH-1:0]            tag_index,
    input  logic [TAG_WIDTH-1:0]              tag_rd,
    input  logic [1:0]                        state_rd,
    output logic                              state_we,
    output logic [1:0]                        state_wdata,
    output logic                              data_rd_en,
    output logic [$clog2(WORDS_PER_LINE)-1:0] data_word,
    input  logic [DATA_WIDTH-1:0]             data_rd,
    output logic                              flush_valid,
    output logic [DATA_WIDTH-1:0]             flush_data,
    output logic                              flush_last,
    input  logic                              flush_ready,
    output logic                              snoop_done,
    output logic                              snoop_hit,
    output logic                              shared,
    output logic                              protocol_error
);

    localparam int WORD_W = $clog2(WORDS_PER_LINE);

    localparam logic [1:0] BUS_READ    = 2'd1;
    localparam logic [1:0] BUS_READEX  = 2'd2;
    localparam logic [1:0] BUS_UPGRADE = 2'd3;

    localparam logic [1:0] CS_I = 2'd0;
    localparam logic [1:0] CS_S = 2'd1;
    localparam logic [1:0] CS_M = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOOKUP, ST_RESOLVE, ST_FREAD, ST_FSEND, ST_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_next;

    logic [1:0]             r_cmd;
    logic [TAG_WIDTH-1:0]   r_tag;
    logic [INDEX_WIDTH-1:0] r_index;
    logic [WORD_W-1:0]      r_word;
    logic                   r_hit;
    logic                   r_shared;
    logic                   r_perr;
    logic                   r_we;
    logic [1:0]             r_new_state;

    logic                   w_hit;
    logic                   w_is_m;
    logic                   w_is_s;
    logic                   w_flush;
    logic                   w_we;
    logic [1:0]             w_new_state;
    logic                   w_shared;
    logic                   w_perr;
    logic                   w_last;

    assign w_last = (r_word == WORD_W'(WORDS_PER_LINE - 1));

    // Resolution of the array lookup against the registered command
    always_comb begin
        w_hit       = (tag_rd == r_tag) && (state_rd != CS_I);
        w_is_m      = w_hit && (state_rd == CS_M);
        w_is_s      = w_hit && (state_rd == CS_S);
        w_flush     = w_is_m && ((r_cmd == BUS_READ) || (r_cmd == BUS_READEX));
        w_we        = w_flush || (w_is_s && ((r_cmd == BUS_READEX) || (r_cmd == BUS_UPGRADE)));
        w_new_state = (w_is_m && (r_cmd == BUS_READ)) ? CS_S : CS_I;
        w_shared    = (w_is_m || w_is_s) && (r_cmd == BUS_READ);
        w_perr      = w_is_m && (r_cmd == BUS_UPGRADE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (snoop_valid) w_next = ST_LOOKUP;
            ST_LOOKUP:  w_next = ST_RESOLVE;
            ST_RESOLVE: w_next = w_flush ? ST_FREAD : ST_DONE;
            ST_FREAD:   w_next = ST_FSEND;
            ST_FSEND:   if (flush_ready) w_next = w_last ? ST_DONE : ST_FREAD;
            ST_DONE:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // Request capture needs no reset: it is only consumed after an accept
    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE && snoop_valid) begin
            r_cmd   <= snoop_command;
            r_tag   <= snoop_tag;
            r_index <= snoop_index;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_word      <= '0;
            r_hit       <= 1'b0;
            r_shared    <= 1'b0;
            r_perr      <= 1'b0;
            r_we        <= 1'b0;
            r_new_state <= CS_I;
        end else if (r_state == ST_RESOLVE) begin
            r_word      <= '0;
            r_hit       <= w_hit;
            r_shared    <= w_shared;
            r_perr      <= w_perr;
            r_we        <= w_we;
            r_new_state <= w_new_state;
        end else if (r_state == ST_FSEND && flush_ready && !w_last) begin
            r_word      <= r_word + WORD_W'(1);
        end
    end

    always_comb begin
        snoop_ready    = 1'b0;
        tag_index      = '0;
        state_we       = 1'b0;
        state_wdata    = CS_I;
        data_rd_en     = 1'b0;
        data_word      = '0;
        flush_valid    = 1'b0;
        flush_data     = '0;
        flush_last     = 1'b0;
        snoop_done     = 1'b0;
        snoop_hit      = 1'b0;
        shared         = 1'b0;
        protocol_error = 1'b0;
        case (r_state)
            ST_IDLE: snoop_ready = 1'b1;
            ST_LOOKUP, ST_RESOLVE: tag_index = r_index;
            ST_FREAD: begin
                tag_index  = r_index;
                data_rd_en = 1'b1;
                data_word  = r_word;
            end
            // Read stays enabled on the same word so a stalled beat holds its data
            ST_FSEND: begin
                tag_index   = r_index;
                data_rd_en  = 1'b1;
                data_word   = r_word;
                flush_valid = 1'b1;
                flush_data  = data_rd;
                flush_last  = w_last;
            end
            ST_DONE: begin
                tag_index      = r_index;
                snoop_done     = 1'b1;
                snoop_hit      = r_hit;
                shared         = r_shared;
                protocol_error = r_perr;
                state_we       = r_we;
                state_wdata    = r_we ? r_new_state : CS_I;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_msi_snoop_responder.sv
// Scoreboard bench for msi_snoop_responder with a behavioural cache model.
module tb_msi_snoop_responder;
    localparam int TW = 20;
    localparam int IW = 6;
    localparam int W  = 4;
    localparam int DW = 32;
    localparam int WW = 2;
    localparam int NL = 64;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          snoop_valid = 1'b0;
    logic          snoop_ready;
    logic [1:0]    snoop_command = 2'd0;
    logic [TW-1:0] snoop_tag = '0;
    logic [IW-1:0] snoop_index = '0;
    logic [IW-1:0] tag_index;
    logic [TW-1:0] tag_rd = '0;
    logic [1:0]    state_rd = 2'd0;
    logic          state_we;
    logic [1:0]    state_wdata;
    logic          data_rd_en;
    logic [WW-1:0] data_word;
    logic [DW-1:0] data_rd = '0;
    logic          flush_valid;
    logic [DW-1:0] flush_data;
    logic          flush_last;
    logic          flush_ready = 1'b1;
    logic          snoop_done;
    logic          snoop_hit;
    logic          shared;
    logic          protocol_error;

    msi_snoop_responder #(.TAG_WIDTH(TW), .INDEX_WIDTH(IW), .WORDS_PER_LINE(W), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .snoop_valid(snoop_valid), .snoop_ready(snoop_ready), .snoop_command(snoop_command),
        .snoop_tag(snoop_tag), .snoop_index(snoop_index),
        .tag_index(tag_index), .tag_rd(tag_rd), .state_rd(state_rd),
        .state_we(state_we), .state_wdata(state_wdata),
        .data_rd_en(data_rd_en), .data_word(data_word), .data_rd(data_rd),
        .flush_valid(flush_valid), .flush_data(flush_data), .flush_last(flush_last),
        .flush_ready(flush_ready), .snoop_done(snoop_done), .snoop_hit(snoop_hit),
        .shared(shared), .protocol_error(protocol_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Cache arrays seen by the DUT
    logic [TW-1:0] env_tag [NL];
    logic [1:0]    env_st  [NL];
    logic [DW-1:0] env_data[NL][W];
    logic          poke_en = 1'b0;
    logic [IW-1:0] poke_idx = '0;
    logic [TW-1:0] poke_tag = '0;
    logic [1:0]    poke_st = 2'd0;

    always @(posedge clk) begin
        tag_rd   <= env_tag[tag_index];
        state_rd <= env_st[tag_index];
        if (data_rd_en) data_rd <= env_data[tag_index][data_word];
        if (poke_en) begin
            env_tag[poke_idx] <= poke_tag;
            env_st[poke_idx]  <= poke_st;
        end else if (state_we) begin
            env_st[tag_index] <= state_wdata;
        end
    end

    // Reference model state and scoreboard
    logic [1:0] ref_st[NL];

    typedef struct packed {
        int         acc;
        logic       flush;
        logic       we;
        logic [1:0] nst;
        logic       hit;
        logic       shr;
        logic       perr;
    } exp_t;

    exp_t        exp_q[$];
    logic [DW:0] beat_q[$];

    int n_chk = 0;
    int n_pass = 0;
    int last_lat = -1;
    int rdy_mode = 0;
    int stall_from = 1 << 30;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // flush_ready changes just after the active edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: flush_ready = 1'b1;
                1: flush_ready = ($urandom_range(0, 3) != 0);
                default: flush_ready = !(cyc >= stall_from && cyc < stall_from + 3);
            endcase
        end
    end

    // Monitor
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    int            stalls = 0;
    initial begin
        exp_t e;
        logic [DW:0] b;
        int lat, exp_lat;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                exp_q.delete();
                beat_q.delete();
                stalls = 0;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid_hold", flush_valid, 1);
                    chk("stall_data_hold", flush_data, prev_data);
                end
                if (flush_valid && flush_ready) begin
                    chk("beat_expected", beat_q.size() != 0, 1);
                    if (beat_q.size() != 0) begin
                        b = beat_q.pop_front();
                        chk("beat_data", flush_data, b[DW-1:0]);
                        chk("beat_last", flush_last, b[DW]);
                    end
                end
                prev_stall = flush_valid && !flush_ready;
                prev_data  = flush_data;
                if (prev_stall) stalls++;
                if (state_we) chk("state_we_only_in_done", snoop_done, 1);
                if (snoop_done) begin
                    chk("done_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("snoop_hit", snoop_hit, e.hit);
                        chk("shared", shared, e.shr);
                        chk("protocol_error", protocol_error, e.perr);
                        chk("state_we", state_we, e.we);
                        if (e.we) chk("state_wdata", state_wdata, e.nst);
                        chk("beats_consumed", beat_q.size(), 0);
                        lat = cyc - e.acc;
                        exp_lat = e.flush ? (3 + 2 * W + stalls) : 3;
                        chk("done_latency", lat, exp_lat);
                        last_lat = lat;
                    end
                    stalls = 0;
                end
            end
        end
    end

    task automatic poke(input int idx, input logic [TW-1:0] tag, input logic [1:0] st);
        @(negedge clk);
        poke_en = 1'b1;
        poke_idx = IW'(idx);
        poke_tag = tag;
        poke_st = st;
        ref_st[idx] = st;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    task automatic issue(input logic [1:0] cmd, input logic [TW-1:0] tag, input int idx, output int acc);
        exp_t e;
        int n;
        logic [1:0] cur;
        @(negedge clk);
        snoop_valid = 1'b1;
        snoop_command = cmd;
        snoop_tag = tag;
        snoop_index = IW'(idx);
        n = 0;
        while (!snoop_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        acc = cyc;
        if (!snoop_ready) begin
            chk("accept_timeout", snoop_ready, 1);
            snoop_valid = 1'b0;
            return;
        end
        // Spec-level outcome of the snoop against the current line
        cur = ref_st[idx];
        e = '0;
        e.acc = acc;
        e.hit = (env_tag[idx] == tag) && (cur != 2'd0);
        if (e.hit && cur == 2'd2) begin
            if (cmd == 2'd1) begin e.flush = 1; e.we = 1; e.nst = 2'd1; e.shr = 1; end
            else if (cmd == 2'd2) begin e.flush = 1; e.we = 1; e.nst = 2'd0; end
            else if (cmd == 2'd3) e.perr = 1;
        end else if (e.hit && cur == 2'd1) begin
            if (cmd == 2'd1) e.shr = 1;
            else if (cmd != 2'd0) begin e.we = 1; e.nst = 2'd0; end
        end
        if (e.we) ref_st[idx] = e.nst;
        exp_q.push_back(e);
        if (e.flush)
            for (int k = 0; k < W; k++) beat_q.push_back({k == W - 1, env_data[idx][k]});
        @(posedge clk);
        #1 snoop_valid = 1'b0;
        snoop_command = 2'($urandom);
        snoop_tag = TW'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, idx;
        logic [TW-1:0] t;
        logic [1:0] saved;
        logic [49:0] outs;
        for (int i = 0; i < NL; i++)
            for (int k = 0; k < W; k++) env_data[i][k] = $urandom;
        for (int i = 0; i < NL; i++) ref_st[i] = 2'd0;

        // Reset state
        snoop_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_ready", snoop_ready, 1);
        outs = {tag_index, state_we, state_wdata, data_rd_en, data_word, flush_valid,
                flush_data, flush_last, snoop_done, snoop_hit, shared, protocol_error};
        chk("reset_outputs", outs, 0);
        snoop_valid = 1'b0;
        reset_n = 1'b1;

        for (int i = 0; i < NL; i++) poke(i, TW'($urandom), 2'($urandom_range(0, 2)));

        // M line, bus_read, 4 beats, shared
        rdy_mode = 0;
        poke(5, 20'h12345, 2'd2);
        issue(2'd1, 20'h12345, 5, acc);
        drain();
        chk("lat_read_flush", last_lat, 11);
        chk("state_after_read", env_st[5], 2'd1);

        // M line, bus_readex with beat 1 stalled 3 cycles
        poke(5, 20'h12345, 2'd2);
        stall_from = 1 << 30;
        rdy_mode = 2;
        @(negedge clk);
        stall_from = cyc + 1 + 6;
        issue(2'd2, 20'h12345, 5, acc);
        stall_from = acc + 6;
        drain();
        rdy_mode = 0;
        chk("lat_readex_stall", last_lat, 14);
        chk("state_after_readex", env_st[5], 2'd0);

        // S line, bus_upgrade
        poke(7, 20'h0ABCD, 2'd1);
        issue(2'd3, 20'h0ABCD, 7, acc);
        drain();
        chk("lat_upgrade_s", last_lat, 3);
        chk("state_after_upgrade", env_st[7], 2'd0);

        // Tag mismatch on an M line
        poke(8, 20'h00F0F, 2'd2);
        issue(2'd1, 20'h00F0E, 8, acc);
        drain();
        chk("lat_miss", last_lat, 3);
        chk("state_after_miss", env_st[8], 2'd2);

        // bus_upgrade against M
        poke(9, 20'h55555, 2'd2);
        issue(2'd3, 20'h55555, 9, acc);
        drain();
        chk("lat_perr", last_lat, 3);
        chk("state_after_perr", env_st[9], 2'd2);

        // Randomized traffic, back to back, random flush_ready
        rdy_mode = 1;
        for (int n = 0; n < 160; n++) begin
            if (n % 4 == 0) begin
                drain();
                poke($urandom_range(0, NL - 1), TW'($urandom), 2'($urandom_range(0, 2)));
            end
            idx = $urandom_range(0, NL - 1);
            t = ($urandom_range(0, 9) < 7) ? env_tag[idx] : TW'($urandom);
            issue(2'($urandom_range(0, 3)), t, idx, acc);
        end
        drain();
        rdy_mode = 0;

        // Reset during beat 2 of a flush
        poke(9, 20'h33333, 2'd2);
        saved = ref_st[9];
        issue(2'd1, 20'h33333, 9, acc);
        for (int n = 0; n < 50 && cyc < acc + 8; n++) @(negedge clk);
        chk("flush_before_reset", flush_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset_ready", snoop_ready, 1);
        outs = {tag_index, state_we, state_wdata, data_rd_en, data_word, flush_valid,
                flush_data, flush_last, snoop_done, snoop_hit, shared, protocol_error};
        chk("midreset_outputs", outs, 0);
        repeat (3) @(negedge clk);
        chk("state_kept_on_abort", env_st[9], 2'd2);
        ref_st[9] = saved;
        reset_n = 1'b1;
        issue(2'd1, 20'h33333, 9, acc);
        drain();
        chk("lat_after_reset", last_lat, 11);

        for (int i = 0; i < NL; i++) chk("final_state_array", env_st[i], ref_st[i]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
